// File: rtl/spike_scheduler.sv
// rtl/spike_scheduler.sv - round-robin spike arbiter, spike queue and timestep sequencer for the MAC bank
module spike_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 12,
    parameter int FIFO_DEPTH  = 8,
    parameter int TS_CYCLES   = 16,
    parameter int INIT_CYCLES = 2
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      mac_set,
    output logic [ADDR_W-1:0]         mac_addr,
    output logic                      mac_addr_valid,
    output logic                      mac_clear,
    output logic [15:0]               timestep_count,
    output logic                      fifo_full
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = $clog2(TS_CYCLES);
    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, INIT, RUN, CLR} state_t;

    state_t            state;
    logic [PW-1:0]     phase;
    logic [IW-1:0]     init_cnt;
    logic [GW-1:0]     prio_ptr;
    logic [GW-1:0]     grant;
    logic              grant_found;
    logic [ADDR_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              push;
    logic              pop;
    logic              last_phase;

    always_comb begin
        logic [GW-1:0] idx;
        idx         = '0;
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = GW'((int'(prio_ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[idx]) begin
                grant       = idx;
                grant_found = 1'b1;
            end
        end
    end

    // Gated by RST_N so the accept stays low for the whole time reset is held.
    always_comb begin
        req_ready = '0;
        if (RST_N && grant_found && !fifo_full) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign push       = |(req_valid & req_ready);
    assign last_phase = (phase == PW'(TS_CYCLES - 2));
    // No pop on the last RUN cycle: its result would land in the CLR cycle, which must stay silent.
    assign pop        = (state == RUN) && (count != '0) && !last_phase;

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_addr[int'(grant)*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            prio_ptr  <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                prio_ptr <= GW'((int'(grant) + 1) % NUM_REQ);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count     <= count + 1'b1;
                fifo_full <= (count == (AW+1)'(FIFO_DEPTH - 1));
            end else if (pop && !push) begin
                count     <= count - 1'b1;
                fifo_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state          <= IDLE;
            phase          <= '0;
            init_cnt       <= '0;
            mac_set        <= 1'b0;
            mac_clear      <= 1'b0;
            mac_addr_valid <= 1'b0;
            mac_addr       <= '0;
            timestep_count <= '0;
        end else begin
            mac_addr_valid <= pop;
            if (pop) begin
                mac_addr <= fifo_mem[rd_ptr];
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= INIT;
                        init_cnt <= '0;
                        mac_set  <= 1'b1;
                    end
                end
                INIT: begin
                    if (init_cnt == IW'(INIT_CYCLES - 1)) begin
                        state   <= RUN;
                        phase   <= '0;
                        mac_set <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (last_phase) begin
                        state          <= CLR;
                        mac_clear      <= 1'b1;
                        timestep_count <= timestep_count + 1'b1;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                CLR: begin
                    mac_clear <= 1'b0;
                    phase     <= '0;
                    state     <= enable ? RUN : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
